// File: rtl/protocol_fsm_if.sv
// Request, encoder and decoder signals of the protocol transaction FSM.
// The master side drives requests and link responses; slave is the FSM.
interface protocol_fsm_if;
  logic        input_ready;
  logic        send_in;
  logic [6:0]  addr;
  logic [3:0]  endp;
  logic [63:0] data_down;
  logic        free;
  logic        bad;
  logic        recv_ready;
  logic [63:0] data_up;
  logic        pkt_valid;
  logic [3:0]  pkt_pid;
  logic [6:0]  pkt_addr;
  logic [3:0]  pkt_endp;
  logic [63:0] pkt_data;
  logic        enc_done;
  logic        dec_valid;
  logic [3:0]  dec_pid;
  logic [63:0] dec_data;
  logic        dec_error;

  modport master (
    output input_ready, send_in, addr, endp,
    output data_down, enc_done,
    output dec_valid, dec_pid, dec_data,
    output dec_error,
    input  free, bad, recv_ready, data_up,
    input  pkt_valid, pkt_pid, pkt_addr,
    input  pkt_endp, pkt_data
  );

  modport slave (
    input  input_ready, send_in, addr, endp,
    input  data_down, enc_done,
    input  dec_valid, dec_pid, dec_data,
    input  dec_error,
    output free, bad, recv_ready, data_up,
    output pkt_valid, pkt_pid, pkt_addr,
    output pkt_endp, pkt_data
  );
endinterface

// File: rtl/protocol_fsm.sv
// Host-side transaction FSM: token, data, handshake, retry and timeout.
// One request in flight; failed attempts retransmit from the token.
module protocol_fsm #(
  parameter int TIMEOUT   = 255,
  parameter int MAX_TRIES = 8
) (
  input  logic          clk,
  input  logic          rst_L,
  protocol_fsm_if.slave bus
);
  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam int         RW        = $clog2(MAX_TRIES + 1);
  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, TOKEN, DATA, WAIT_HS,
    WAIT_DATA, SEND_HS, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [6:0]    addr_q, addr_d;
  logic [3:0]    endp_q, endp_d;
  logic [63:0]   data_q, data_d;
  logic [63:0]   up_q, up_d;
  logic          send_in_q, send_in_d;
  logic          hs_ack_q, hs_ack_d;
  logic          bad_q, bad_d;
  logic          recv_q, recv_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [7:0]    timer_q, timer_d;
  logic          fail;
  logic          timed_out;
  logic          ack_ok;
  logic          data_ok;
  logic          pkt_valid;
  logic [3:0]    pkt_pid;

  assign timed_out = (timer_q == TO_LAST);
  assign ack_ok  = !bus.dec_error
                && (bus.dec_pid == PID_ACK);
  assign data_ok = !bus.dec_error
                && (bus.dec_pid == PID_DATA0);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    endp_d    = endp_q;
    data_d    = data_q;
    up_d      = up_q;
    send_in_d = send_in_q;
    hs_ack_d  = hs_ack_q;
    recv_d    = recv_q;
    retry_d   = retry_q;
    timer_d   = timer_q;
    bad_d     = 1'b0;
    fail      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.input_ready) begin
          addr_d    = bus.addr;
          endp_d    = bus.endp;
          data_d    = bus.data_down;
          send_in_d = bus.send_in;
          retry_d   = '0;
          recv_d    = 1'b0;
          state_d   = TOKEN;
        end
      end
      TOKEN: begin
        if (bus.enc_done) begin
          timer_d = '0;
          state_d = send_in_q ? WAIT_DATA : DATA;
        end
      end
      DATA: begin
        if (bus.enc_done) begin
          timer_d = '0;
          state_d = WAIT_HS;
        end
      end
      WAIT_HS: begin
        if (bus.dec_valid) begin
          if (ack_ok) state_d = DONE;
          else        fail    = 1'b1;
        end else if (timed_out) begin
          fail = 1'b1;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      WAIT_DATA: begin
        // a bad data packet is answered with NAK before retrying
        if (bus.dec_valid) begin
          hs_ack_d = data_ok;
          if (data_ok) up_d = bus.dec_data;
          state_d = SEND_HS;
        end else if (timed_out) begin
          fail = 1'b1;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      SEND_HS: begin
        if (bus.enc_done) begin
          if (hs_ack_q) begin
            recv_d  = 1'b1;
            state_d = DONE;
          end else begin
            fail = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (fail) begin
      retry_d = retry_q + RW'(1);
      if (int'(retry_q) + 1 < MAX_TRIES) begin
        state_d = TOKEN;
      end else begin
        bad_d   = 1'b1;
        state_d = IDLE;
      end
    end
  end

  always_comb begin
    pkt_valid = 1'b0;
    pkt_pid   = '0;
    unique case (state_q)
      TOKEN: begin
        pkt_valid = 1'b1;
        pkt_pid   = send_in_q ? PID_IN : PID_OUT;
      end
      DATA: begin
        pkt_valid = 1'b1;
        pkt_pid   = PID_DATA0;
      end
      SEND_HS: begin
        pkt_valid = 1'b1;
        pkt_pid   = hs_ack_q ? PID_ACK : PID_NAK;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_L) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      endp_q    <= '0;
      data_q    <= '0;
      up_q      <= '0;
      send_in_q <= 1'b0;
      hs_ack_q  <= 1'b0;
      recv_q    <= 1'b0;
      retry_q   <= '0;
      timer_q   <= '0;
      bad_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      endp_q    <= endp_d;
      data_q    <= data_d;
      up_q      <= up_d;
      send_in_q <= send_in_d;
      hs_ack_q  <= hs_ack_d;
      recv_q    <= recv_d;
      retry_q   <= retry_d;
      timer_q   <= timer_d;
      bad_q     <= bad_d;
    end
  end

  assign bus.free       = (state_q == IDLE);
  assign bus.bad        = bad_q;
  assign bus.recv_ready = recv_q;
  assign bus.data_up    = up_q;
  assign bus.pkt_valid  = pkt_valid;
  assign bus.pkt_pid    = pkt_pid;
  assign bus.pkt_addr   = addr_q;
  assign bus.pkt_endp   = endp_q;
  assign bus.pkt_data   = data_q;
endmodule

// File: tb/tb_protocol_fsm.sv
// Bench for protocol_fsm: cycle table, corner sequences, random
// transactions checked against a transaction-level outcome model.
module tb_protocol_fsm;
  localparam int TIMEOUT   = 255;
  localparam int MAX_TRIES = 8;
  localparam logic [3:0] P_OUT   = 4'b0001;
  localparam logic [3:0] P_IN    = 4'b1001;
  localparam logic [3:0] P_DATA0 = 4'b0011;
  localparam logic [3:0] P_ACK   = 4'b0010;
  localparam logic [3:0] P_NAK   = 4'b1010;
  localparam logic [63:0] CAFE = 64'hDEADBEEF_0000CAFE;
  localparam int K_GOOD  = 0;
  localparam int K_NAK   = 1;
  localparam int K_ERR   = 2;
  localparam int K_OTHER = 3;
  localparam int K_TMO   = 4;

  logic clk = 1'b0;
  logic rst_L;
  always #5 clk = ~clk;

  protocol_fsm_if bus();

  protocol_fsm #(
    .TIMEOUT  (TIMEOUT),
    .MAX_TRIES(MAX_TRIES)
  ) dut (
    .clk  (clk),
    .rst_L(rst_L),
    .bus  (bus.slave)
  );

  typedef struct {
    logic       ir;
    logic       si;
    logic [6:0] a;
    logic [3:0] e;
    logic       ed;
    logic       dv;
    logic [3:0] dp;
    logic       f;
    logic       pv;
    logic [3:0] pp;
    logic       rr;
  } vec_t;

  vec_t        tbl[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          tok_cnt = 0;
  int          bad_cnt = 0;
  logic [63:0] exp_up;
  logic        exp_rr;
  logic [6:0]  lat_a;
  logic [3:0]  lat_e;
  int          oc_kind[MAX_TRIES];
  int          oc_dly[MAX_TRIES];

  always @(posedge clk) if (bus.bad === 1'b1) bad_cnt++;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  function automatic vec_t mk(
    logic ir, logic si, logic [6:0] a, logic [3:0] e,
    logic ed, logic dv, logic [3:0] dp,
    logic f, logic pv, logic [3:0] pp, logic rr);
    vec_t v;
    v.ir = ir; v.si = si; v.a = a; v.e = e;
    v.ed = ed; v.dv = dv; v.dp = dp;
    v.f = f; v.pv = pv; v.pp = pp; v.rr = rr;
    return v;
  endfunction

  task automatic step();
    @(negedge clk);
    bus.input_ready = 1'b0;
    bus.enc_done    = 1'b0;
    bus.dec_valid   = 1'b0;
    bus.dec_error   = 1'b0;
    bus.send_in     = 1'($urandom);
    bus.addr        = 7'($urandom);
    bus.endp        = 4'($urandom);
    bus.data_down   = {$urandom, $urandom};
    bus.dec_pid     = 4'($urandom);
    bus.dec_data    = {$urandom, $urandom};
  endtask

  task automatic serve_pkt(input logic [3:0] pid,
                           input logic [6:0] a,
                           input logic [3:0] e,
                           input logic [63:0] d,
                           output int waited);
    int hold;
    waited = 0;
    step();
    while (bus.pkt_valid !== 1'b1 && waited < 400) begin
      waited++;
      step();
    end
    chk("pkt_pid", bus.pkt_pid, pid);
    if (pid == P_OUT || pid == P_IN) begin
      tok_cnt++;
      chk("pkt_addr", bus.pkt_addr, a);
      chk("pkt_endp", bus.pkt_endp, e);
    end
    if (pid == P_DATA0) chk("pkt_data", bus.pkt_data, d);
    hold = $urandom_range(0, 2);
    repeat (hold) begin
      if ($urandom_range(0, 1) == 1) bus.dec_valid = 1'b1;
      if ($urandom_range(0, 3) == 0) bus.input_ready = 1'b1;
      step();
      chk("pkt_hold_valid", bus.pkt_valid, 1'b1);
      chk("pkt_hold_pid", bus.pkt_pid, pid);
    end
    bus.enc_done = 1'b1;
  endtask

  task automatic run_txn(input logic si,
                         input logic [6:0] a,
                         input logic [3:0] e,
                         input logic [63:0] d);
    int w, tok0, bad0, exp_tok, kind;
    bit ok, tmo;
    logic [3:0]  tok;
    logic [63:0] gd;
    tok = si ? P_IN : P_OUT;
    exp_tok = MAX_TRIES;
    for (int k = MAX_TRIES - 1; k >= 0; k--)
      if (oc_kind[k] == K_GOOD) exp_tok = k + 1;
    tok0 = tok_cnt;
    bad0 = bad_cnt;
    gd = '0;
    w = 0;
    while (bus.free !== 1'b1 && w < 400) begin
      w++;
      step();
    end
    chk("req_free", bus.free, 1'b1);
    bus.input_ready = 1'b1;
    bus.send_in     = si;
    bus.addr        = a;
    bus.endp        = e;
    bus.data_down   = d;
    exp_rr = 1'b0;
    ok  = 1'b0;
    tmo = 1'b0;
    for (int k = 0; k < MAX_TRIES && !ok; k++) begin
      serve_pkt(tok, a, e, d, w);
      chk(k == 0 ? "accept_latency" : "retry_latency",
          w, tmo ? TIMEOUT : 0);
      if (k == 0) chk("recv_cleared", bus.recv_ready, 1'b0);
      if (!si) begin
        serve_pkt(P_DATA0, a, e, d, w);
        chk("data_latency", w, 0);
      end
      kind = oc_kind[k];
      tmo  = (kind == K_TMO);
      if (!tmo) begin
        repeat (oc_dly[k]) begin
          step();
          chk("wait_quiet", bus.pkt_valid, 1'b0);
          if ($urandom_range(0, 3) == 0) bus.enc_done = 1'b1;
        end
        step();
        gd = {$urandom, $urandom};
        bus.dec_valid = 1'b1;
        bus.dec_error = (kind == K_ERR);
        bus.dec_data  = gd;
        if (kind == K_GOOD || kind == K_ERR)
          bus.dec_pid = si ? P_DATA0 : P_ACK;
        else if (kind == K_NAK)
          bus.dec_pid = P_NAK;
        else
          bus.dec_pid = si ? P_ACK : P_DATA0;
        if (si) begin
          serve_pkt(kind == K_GOOD ? P_ACK : P_NAK, a, e, d, w);
          chk("hs_latency", w, 0);
        end
        ok = (kind == K_GOOD);
      end
      if (ok) begin
        step();
        chk("done_free", bus.free, 1'b0);
        chk("done_pkt_valid", bus.pkt_valid, 1'b0);
        step();
        chk("ok_free", bus.free, 1'b1);
        chk("ok_bad", bus.bad, 1'b0);
        if (si) exp_up = gd;
        exp_rr = si;
        chk("ok_recv", bus.recv_ready, exp_rr);
      end else if (k == MAX_TRIES - 1) begin
        w = 0;
        step();
        while (bus.free !== 1'b1 && w < 400) begin
          w++;
          step();
        end
        chk("abort_latency", w, tmo ? TIMEOUT : 0);
        chk("abort_bad", bus.bad, 1'b1);
        step();
        chk("abort_bad_pulse", bus.bad, 1'b0);
        chk("abort_free", bus.free, 1'b1);
        repeat (2) begin
          step();
          chk("abort_no_token", bus.pkt_valid, 1'b0);
        end
      end
    end
    step();
    chk("txn_tokens", tok_cnt - tok0, exp_tok);
    chk("txn_bad", bad_cnt - bad0, ok ? 0 : 1);
    chk("txn_data_up", bus.data_up, exp_up);
    chk("txn_recv", bus.recv_ready, exp_rr);
  endtask

  task automatic set_all(input int kind, input int dly);
    for (int k = 0; k < MAX_TRIES; k++) begin
      oc_kind[k] = kind;
      oc_dly[k]  = dly;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w, b0, r;
    bit hostile;
    rst_L = 1'b0;
    bus.input_ready = 1'b0;
    bus.send_in     = 1'b0;
    bus.addr        = '0;
    bus.endp        = '0;
    bus.data_down   = '0;
    bus.enc_done    = 1'b0;
    bus.dec_valid   = 1'b0;
    bus.dec_pid     = '0;
    bus.dec_data    = '0;
    bus.dec_error   = 1'b0;
    exp_up = '0;
    exp_rr = 1'b0;
    lat_a  = '0;
    lat_e  = '0;
    repeat (3) @(negedge clk);
    chk("rst_free", bus.free, 1'b1);
    chk("rst_bad", bus.bad, 1'b0);
    chk("rst_recv", bus.recv_ready, 1'b0);
    chk("rst_data_up", bus.data_up, 64'h0);
    chk("rst_pkt_valid", bus.pkt_valid, 1'b0);
    chk("rst_pkt_pid", bus.pkt_pid, 4'h0);
    chk("rst_pkt_addr", bus.pkt_addr, 7'h0);
    chk("rst_pkt_endp", bus.pkt_endp, 4'h0);
    chk("rst_pkt_data", bus.pkt_data, 64'h0);
    rst_L = 1'b1;

    // OUT to (5,4) acked, then IN from endpoint 8
    tbl.push_back(mk(1, 0, 5, 4, 0, 0, 0,       1, 0, 0,       0));
    tbl.push_back(mk(1, 0, 9, 1, 0, 0, 0,       0, 1, P_OUT,   0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,       0, 1, P_OUT,   0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, P_ACK,   0, 1, P_DATA0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,       0, 1, P_DATA0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,       0, 0, 0,       0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, P_ACK,   0, 0, 0,       0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,       1, 0, 0,       0));
    tbl.push_back(mk(1, 1, 3, 8, 0, 0, 0,       1, 0, 0,       0));
    tbl.push_back(mk(1, 0, 7, 2, 0, 0, 0,       0, 1, P_IN,    0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,       0, 1, P_IN,    0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,       0, 0, 0,       0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, P_DATA0, 0, 0, 0,       0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,       0, 1, P_ACK,   0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,       1, 0, 0,       1));
    foreach (tbl[i]) begin
      @(negedge clk);
      chk($sformatf("tbl%0d_free", i), bus.free, tbl[i].f);
      chk($sformatf("tbl%0d_pv", i), bus.pkt_valid, tbl[i].pv);
      chk($sformatf("tbl%0d_bad", i), bus.bad, 1'b0);
      chk($sformatf("tbl%0d_recv", i), bus.recv_ready, tbl[i].rr);
      if (tbl[i].pv)
        chk($sformatf("tbl%0d_pid", i), bus.pkt_pid, tbl[i].pp);
      if (tbl[i].pv && (tbl[i].pp == P_OUT || tbl[i].pp == P_IN)) begin
        chk($sformatf("tbl%0d_addr", i), bus.pkt_addr, lat_a);
        chk($sformatf("tbl%0d_endp", i), bus.pkt_endp, lat_e);
      end
      if (tbl[i].pv && tbl[i].pp == P_DATA0)
        chk($sformatf("tbl%0d_data", i), bus.pkt_data, 64'h1234);
      bus.input_ready = tbl[i].ir;
      bus.send_in     = tbl[i].si;
      bus.addr        = tbl[i].a;
      bus.endp        = tbl[i].e;
      bus.data_down   = 64'h1234;
      bus.enc_done    = tbl[i].ed;
      bus.dec_valid   = tbl[i].dv;
      bus.dec_pid     = tbl[i].dp;
      bus.dec_error   = 1'b0;
      bus.dec_data    = CAFE;
      if (tbl[i].ir && tbl[i].f) begin
        lat_a = tbl[i].a;
        lat_e = tbl[i].e;
      end
    end
    step();
    chk("tbl_data_up", bus.data_up, CAFE);
    chk("tbl_bad_never", bad_cnt, 0);
    exp_up = CAFE;
    exp_rr = 1'b1;

    set_all(K_NAK, 2);
    oc_kind[7] = K_GOOD;
    run_txn(1'b0, 7'd5, 4'd4, 64'h1234);
    set_all(K_NAK, 1);
    run_txn(1'b0, 7'd5, 4'd4, 64'h1234);
    set_all(K_GOOD, 3);
    oc_kind[0] = K_ERR;
    run_txn(1'b1, 7'd9, 4'd8, 64'h0);
    oc_kind[0] = K_TMO;
    run_txn(1'b1, 7'd9, 4'd8, 64'h0);
    set_all(K_GOOD, 254);
    run_txn(1'b1, 7'd1, 4'd2, 64'h0);
    run_txn(1'b0, 7'd1, 4'd2, 64'h77);
    set_all(K_TMO, 0);
    run_txn(1'b1, 7'd3, 4'd3, 64'h0);
    set_all(K_OTHER, 0);
    run_txn(1'b0, 7'd4, 4'd6, 64'h99);

    w = 0;
    while (bus.free !== 1'b1 && w < 400) begin
      w++;
      step();
    end
    b0 = bad_cnt;
    bus.input_ready = 1'b1;
    bus.send_in     = 1'b0;
    bus.addr        = 7'h11;
    bus.endp        = 4'h2;
    bus.data_down   = 64'hA5A5;
    serve_pkt(P_OUT, 7'h11, 4'h2, 64'hA5A5, w);
    step();
    chk("rst_pre_pv", bus.pkt_valid, 1'b1);
    chk("rst_pre_pid", bus.pkt_pid, P_DATA0);
    bus.input_ready = 1'b1;
    step();
    chk("busy_ir_pid", bus.pkt_pid, P_DATA0);
    chk("busy_ir_free", bus.free, 1'b0);
    rst_L = 1'b0;
    step();
    chk("rst_mid_pv", bus.pkt_valid, 1'b0);
    chk("rst_mid_free", bus.free, 1'b1);
    chk("rst_mid_bad", bus.bad, 1'b0);
    chk("rst_mid_data_up", bus.data_up, 64'h0);
    rst_L = 1'b1;
    exp_up = '0;
    exp_rr = 1'b0;
    step();
    step();
    chk("rst_mid_no_bad", bad_cnt - b0, 0);

    for (int t = 0; t < 40; t++) begin
      hostile = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < MAX_TRIES; k++) begin
        r = $urandom_range(0, 19);
        if (r == 0)      oc_kind[k] = K_TMO;
        else if (r < 4)  oc_kind[k] = K_NAK;
        else if (r < 6)  oc_kind[k] = K_ERR;
        else if (r < 7)  oc_kind[k] = K_OTHER;
        else if (hostile) oc_kind[k] = K_NAK;
        else             oc_kind[k] = K_GOOD;
        oc_dly[k] = ($urandom_range(0, 19) == 0)
                  ? 254 : $urandom_range(0, 10);
      end
      run_txn(1'($urandom), 7'($urandom), 4'($urandom),
              {$urandom, $urandom});
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
